// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order word fetch, response queue to decode, redirect flush.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_unit_if.master    imem,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               stall_d,
    output logic               instr_valid_d,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic               fetch_misalign
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      qdata_q [DEPTH];
    logic [31:0]      qdata_d [DEPTH];
    logic [31:0]      qpc_q [DEPTH];
    logic [31:0]      qpc_d [DEPTH];
    logic             halted_q, halted_d;
    logic             misalign_q, misalign_d;

    logic [CNT_W:0]   credit_used;
    logic             issue_ok;
    logic             fire;
    logic             rsp_ok;
    logic             push;
    logic             pop;
    logic [31:0]      target;
    logic             misaligned;

`ifdef IF_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign misaligned = |redirect_pc[1:0];
`else
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
`endif

    // Queue entries plus in-flight fetches may never exceed DEPTH, so a kept response always has a slot.
    assign credit_used         = {1'b0, count_q} + {1'b0, outstanding_q};
    assign issue_ok            = (credit_used < DEPTH_C) && !halted_q;
    assign imem.imem_req_valid = rst_n && issue_ok && !redirect_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign fire   = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_ok = imem.imem_rsp_valid && (outstanding_q != '0);
    assign push   = rsp_ok && (drop_q == '0) && !redirect_valid;
    assign pop    = (count_q != '0) && !stall_d;

    assign instr_valid_d  = (count_q != '0);
    assign instr_d        = instr_valid_d ? qdata_q[head_q] : NOP;
    assign pc_d           = instr_valid_d ? qpc_q[head_q] : 32'h0;
    assign fetch_misalign = misalign_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        qdata_d       = qdata_q;
        qpc_d         = qpc_q;
        halted_d      = halted_q;
        misalign_d    = misalign_q;

        if (fire && !rsp_ok) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!fire && rsp_ok) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end

        if (push) begin
            qdata_d[tail_q] = imem.imem_rsp_data;
            qpc_d[tail_q]   = rsp_pc_q;
            tail_d          = tail_q + PTR_W'(1);
            rsp_pc_d        = rsp_pc_q + 32'd4;
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Redirect wins: everything still in flight after this cycle's accounting becomes stale.
        if (redirect_valid) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            drop_d     = outstanding_d;
            halted_d   = misaligned;
            misalign_d = misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            qdata_q       <= '{default: '0};
            qpc_q         <= '{default: '0};
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            qdata_q       <= qdata_d;
            qpc_q         <= qpc_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: imem model with variable latency, decode-side scoreboard,
// table-driven phase vectors and hand-written redirect/reset sequences.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        instr_valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        fetch_misalign;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .instr_valid_d  (instr_valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        int          cycles;
        logic        exp_req;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    pend_t       pend[$];
    exp_t        sb[$];
    vec_t        vecs[14];
    int          n_cmp;
    int          n_fail;
    int          cyc;
    int          lat;
    logic [31:0] exp_req_pc;
    logic        exp_halt;
    logic        snap_req;
    logic        snap_iv;
    logic [31:0] snap_pc;
    logic [31:0] snap_instr;
    logic        snap_mis;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs and the memory response at negedge, observe just after, then cross the posedge.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic rsp_now;
        exp_t e;
        pend_t p;
        @(negedge clk);
        stall_d            = st;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        bus.imem_req_ready = rdy;
        rsp_now            = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memfun(pend[0].addr);
            rsp_now            = 1'b1;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        snap_req   = bus.imem_req_valid;
        snap_iv    = instr_valid_d;
        snap_pc    = pc_d;
        snap_instr = instr_d;
        snap_mis   = fetch_misalign;

        if (sb.size() == 0) begin
            checkOutput("dec_spurious", {31'h0, instr_valid_d}, 32'h0);
        end else if (instr_valid_d) begin
            checkOutput("dec_pc", pc_d, sb[0].pc);
            checkOutput("dec_instr", instr_d, sb[0].data);
            if (!st) void'(sb.pop_front());
        end

        if (rv) begin
            checkOutput("req_in_redirect", {31'h0, bus.imem_req_valid}, 32'h0);
        end else if (exp_halt) begin
            checkOutput("req_while_halted", {31'h0, bus.imem_req_valid}, 32'h0);
        end else if (bus.imem_req_valid && rdy) begin
            checkOutput("req_addr", bus.imem_req_addr, exp_req_pc);
            e.pc   = exp_req_pc;
            e.data = memfun(exp_req_pc);
            sb.push_back(e);
            p.addr = bus.imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            exp_req_pc = exp_req_pc + 32'd4;
        end

        if (rsp_now) void'(pend.pop_front());

        if (rv) begin
            sb.delete();
`ifdef IF_MISALIGN_TRAP_EN
            exp_halt = (rpc[1:0] != 2'b00);
            exp_req_pc = rpc;
`else
            exp_halt = 1'b0;
            exp_req_pc = rpc & 32'hFFFF_FFFC;
`endif
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic checkReset();
        checkOutput("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        checkOutput("rst_instr_valid", {31'h0, instr_valid_d}, 32'h0);
        checkOutput("rst_instr", instr_d, NOP);
        checkOutput("rst_pc", pc_d, 32'h0);
        checkOutput("rst_misalign", {31'h0, fetch_misalign}, 32'h0);
    endtask

    task automatic resetMidOp();
        #2;
        rst_n              = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        redirect_valid     = 1'b0;
        pend.delete();
        sb.delete();
        exp_req_pc = 32'h0;
        exp_halt   = 1'b0;
        #1;
        checkReset();
        @(posedge clk);
        cyc++;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        lat = 1;
        exp_req_pc = 32'h0;
        exp_halt = 1'b0;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        stall_d = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;

        //           redir rpc            stall cyc  req  iv   pc             mis
        vecs[0]  = '{1'b1, 32'h0000_0100, 1'b1, 8, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 5, 1'b0, 1'b1, 32'h0000_0104, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 1, 1'b0, 1'b1, 32'h0000_0104, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 1'b1, 32'h0000_0108, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0200, 1'b0, 1, 1'b0, 1'b1, 32'h0000_010C, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 6, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 8, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 5, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
`ifdef IF_MISALIGN_TRAP_EN
        vecs[11] = '{1'b1, 32'h0000_0102, 1'b1, 8, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
`else
        vecs[11] = '{1'b1, 32'h0000_0102, 1'b1, 8, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
`endif
        vecs[12] = '{1'b1, 32'h0000_0200, 1'b1, 8, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
        vecs[13] = '{1'b0, 32'h0,         1'b0, 1, 1'b0, 1'b1, 32'h0000_0200, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] streaming after reset release");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] table vectors");
        for (int v = 0; v < 14; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                applyStimulus(vecs[v].stall, (c == 0) ? vecs[v].redir : 1'b0, vecs[v].rpc, 1'b1);
            end
            checkOutput($sformatf("vec%0d_req_valid", v), {31'h0, snap_req}, {31'h0, vecs[v].exp_req});
            checkOutput($sformatf("vec%0d_instr_valid", v), {31'h0, snap_iv}, {31'h0, vecs[v].exp_iv});
            checkOutput($sformatf("vec%0d_pc", v), snap_pc, vecs[v].exp_pc);
            checkOutput($sformatf("vec%0d_instr", v), snap_instr,
                        vecs[v].exp_iv ? memfun(vecs[v].exp_pc) : NOP);
            checkOutput($sformatf("vec%0d_misalign", v), {31'h0, snap_mis}, {31'h0, vecs[v].exp_mis});
        end

        $display("[TB] reset mid-operation, then redirect with two fetches in flight");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        resetMidOp();
        lat = 3;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) lat = $urandom_range(1, 3);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                          $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
